// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline stages and the hazard controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_rs_use_i;
  logic             id_rt_use_i;
  logic             id_muldiv_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_mem_read_i;
  logic             ex_branch_taken_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             idex_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;
  logic             busy_o;
  logic [1:0]       state_o;

  modport master (
    output id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i, id_muldiv_i,
           ex_rd_i, ex_mem_read_i, ex_branch_taken_i,
    input  pc_write_o, ifid_write_o, idex_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, busy_o, state_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i, id_muldiv_i,
           ex_rd_i, ex_mem_read_i, ex_branch_taken_i,
    output pc_write_o, ifid_write_o, idex_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, busy_o, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// mul/div EX occupancy, sequenced by a small FSM with a shared down-counter.
module hazard_ctrl #(
  parameter int REG_W          = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int MULDIV_CYCLES  = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LSTALL  = 2'd1,
    MULDIV  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [5:0]       LSTALL_LOAD = 6'(LOAD_USE_STALL - 1);
  localparam logic [5:0]       MULDIV_LOAD = 6'(MULDIV_CYCLES - 1);
  localparam logic [REG_W-1:0] ZERO_REG    = '0;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_cnt;
  logic [5:0] w_next_cnt;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_hazard;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_flush;
  logic w_busy;

  // Register r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_rs_hit      = bus.id_rs_use_i && (bus.id_rs_i == bus.ex_rd_i);
  assign w_rt_hit      = bus.id_rt_use_i && (bus.id_rt_i == bus.ex_rd_i);
  assign w_load_hazard = bus.ex_mem_read_i && (bus.ex_rd_i != ZERO_REG) &&
                         (w_rs_hit || w_rt_hit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_busy        = 1'b0;

    case (r_state)
      LSTALL: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_idex_flush = 1'b1;
        if (r_cnt <= 6'd1) begin
          w_next_state = RUN;
        end else begin
          w_next_cnt = r_cnt - 6'd1;
        end
      end

      MULDIV: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_write  = 1'b0;
        w_exmem_flush = 1'b1;
        w_busy        = 1'b1;
        if (r_cnt <= 6'd1) begin
          w_next_state = RUN;
        end else begin
          w_next_cnt = r_cnt - 6'd1;
        end
      end

      // RUN, and the unused encoding, which recovers straight to RUN.
      default: begin
        w_next_state = RUN;
        if (bus.ex_branch_taken_i) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (w_load_hazard) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            w_next_state = LSTALL;
            w_next_cnt   = LSTALL_LOAD;
          end
        end else if (bus.id_muldiv_i) begin
          if (MULDIV_CYCLES > 1) begin
            w_next_state = MULDIV;
            w_next_cnt   = MULDIV_LOAD;
          end
        end
      end
    endcase

    // The whole pipeline is frozen while reset is held.
    if (rst_i) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_flush = 1'b0;
      w_busy        = 1'b0;
    end
  end

  assign bus.pc_write_o    = w_pc_write;
  assign bus.ifid_write_o  = w_ifid_write;
  assign bus.idex_write_o  = w_idex_write;
  assign bus.ifid_flush_o  = w_ifid_flush;
  assign bus.idex_flush_o  = w_idex_flush;
  assign bus.exmem_flush_o = w_exmem_flush;
  assign bus.busy_o        = w_busy;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations driven with identical stimulus,
// checked against a remaining-cycles reference model and hand-written vectors.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       br;
    logic       mem_read;
    logic [4:0] rd;
    logic [4:0] rs;
    logic       rs_use;
    logic [4:0] rt;
    logic       rt_use;
    logic       muldiv;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [8:0] exp;
  } vec_t;

  // Output packing: {pc_w, ifid_w, idex_w, ifid_fl, idex_fl, exmem_fl, busy, state[1:0]}
  localparam logic [8:0] O_RST   = 9'b000_000_0_00;
  localparam logic [8:0] O_DEF   = 9'b111_000_0_00;
  localparam logic [8:0] O_STALL = 9'b001_010_0_00;
  localparam logic [8:0] O_LST   = 9'b001_010_0_01;
  localparam logic [8:0] O_BR    = 9'b111_110_0_00;
  localparam logic [8:0] O_MD    = 9'b000_001_1_10;

  localparam int LUS_A = 1;
  localparam int MDC_A = 4;
  localparam int LUS_B = 3;
  localparam int MDC_B = 32;

  logic       clk = 1'b0;
  stim_t      cur;
  int         checkCount = 0;
  int         passCount  = 0;
  int         stallA = 0, busyA = 0, stallB = 0, busyB = 0;
  logic [8:0] obsA, obsB;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5)) ifA ();
  hazard_ctrl_if #(.REG_W(5)) ifB ();

  assign ifA.id_rs_i = cur.rs;             assign ifB.id_rs_i = cur.rs;
  assign ifA.id_rt_i = cur.rt;             assign ifB.id_rt_i = cur.rt;
  assign ifA.id_rs_use_i = cur.rs_use;     assign ifB.id_rs_use_i = cur.rs_use;
  assign ifA.id_rt_use_i = cur.rt_use;     assign ifB.id_rt_use_i = cur.rt_use;
  assign ifA.id_muldiv_i = cur.muldiv;     assign ifB.id_muldiv_i = cur.muldiv;
  assign ifA.ex_rd_i = cur.rd;             assign ifB.ex_rd_i = cur.rd;
  assign ifA.ex_mem_read_i = cur.mem_read; assign ifB.ex_mem_read_i = cur.mem_read;
  assign ifA.ex_branch_taken_i = cur.br;   assign ifB.ex_branch_taken_i = cur.br;

  assign obsA = {ifA.pc_write_o, ifA.ifid_write_o, ifA.idex_write_o, ifA.ifid_flush_o,
                 ifA.idex_flush_o, ifA.exmem_flush_o, ifA.busy_o, ifA.state_o};
  assign obsB = {ifB.pc_write_o, ifB.ifid_write_o, ifB.idex_write_o, ifB.ifid_flush_o,
                 ifB.idex_flush_o, ifB.exmem_flush_o, ifB.busy_o, ifB.state_o};

  hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(LUS_A), .MULDIV_CYCLES(MDC_A)) dutA (
    .clk_i(clk), .rst_i(cur.rst), .bus(ifA)
  );

  hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(LUS_B), .MULDIV_CYCLES(MDC_B)) dutB (
    .clk_i(clk), .rst_i(cur.rst), .bus(ifB)
  );

  function automatic stim_t mk(logic rst, logic br, logic mr, logic [4:0] rd,
                               logic [4:0] rs, logic rsu, logic [4:0] rt,
                               logic rtu, logic md);
    stim_t s;
    s.rst = rst; s.br = br; s.mem_read = mr; s.rd = rd;
    s.rs = rs; s.rs_use = rsu; s.rt = rt; s.rt_use = rtu; s.muldiv = md;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic hazardOf(stim_t s);
    return s.mem_read && (s.rd != 5'd0) &&
           ((s.rs_use && s.rs == s.rd) || (s.rt_use && s.rt == s.rd));
  endfunction

  // Model tracks how many stall / occupancy cycles remain after the current one.
  function automatic logic [8:0] modelOut(stim_t s, int stall, int busy);
    if (s.rst)        return O_RST;
    if (busy > 0)     return O_MD;
    if (stall > 0)    return O_LST;
    if (s.br)         return O_BR;
    if (hazardOf(s))  return O_STALL;
    return O_DEF;
  endfunction

  task automatic modelStep(input stim_t s, input int lus, input int mdc,
                           inout int stall, inout int busy);
    if (s.rst) begin
      stall = 0;
      busy  = 0;
    end else if (busy > 0) begin
      busy = busy - 1;
    end else if (stall > 0) begin
      stall = stall - 1;
    end else if (s.br) begin
      stall = 0;
    end else if (hazardOf(s)) begin
      stall = lus - 1;
    end else if (s.muldiv) begin
      busy = mdc - 1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    cur = s;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances the model.
  task automatic runCycle(input string name, input stim_t s,
                          input logic useA, input logic [8:0] tA,
                          input logic useB, input logic [8:0] tB);
    applyStimulus(s);
    @(negedge clk);
    checkOutput({name, "/modelA"}, obsA, modelOut(s, stallA, busyA));
    checkOutput({name, "/modelB"}, obsB, modelOut(s, stallB, busyB));
    if (useA) checkOutput({name, "/tblA"}, obsA, tA);
    if (useB) checkOutput({name, "/tblB"}, obsB, tB);
    @(posedge clk);
    modelStep(s, LUS_A, MDC_A, stallA, busyA);
    modelStep(s, LUS_B, MDC_B, stallB, busyB);
    #1;
  endtask

  initial begin
    stim_t rstS;
    stim_t s;
    rstS = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(rstS);

    // Vectors for the LUS=1 / MULDIV=4 instance.
    tbl.push_back('{rstS, O_RST});
    tbl.push_back('{idle(), O_DEF});
    tbl.push_back('{mk(0, 0, 1, 5, 5, 1, 0, 0, 0), O_STALL});
    tbl.push_back('{idle(), O_DEF});
    tbl.push_back('{mk(0, 0, 1, 0, 0, 1, 0, 0, 0), O_DEF});
    tbl.push_back('{mk(0, 0, 1, 5, 5, 0, 0, 0, 0), O_DEF});
    tbl.push_back('{mk(0, 0, 1, 7, 0, 0, 7, 1, 0), O_STALL});
    tbl.push_back('{mk(0, 0, 1, 7, 7, 0, 7, 0, 0), O_DEF});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_DEF});
    tbl.push_back('{mk(0, 1, 1, 2, 2, 1, 0, 0, 0), O_MD});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_MD});
    tbl.push_back('{idle(), O_MD});
    tbl.push_back('{idle(), O_DEF});
    tbl.push_back('{mk(0, 1, 1, 4, 4, 1, 0, 0, 1), O_BR});
    tbl.push_back('{idle(), O_DEF});
    tbl.push_back('{mk(0, 0, 1, 3, 3, 1, 0, 0, 1), O_STALL});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_DEF});
    tbl.push_back('{idle(), O_MD});
    tbl.push_back('{idle(), O_MD});
    tbl.push_back('{idle(), O_MD});
    tbl.push_back('{idle(), O_DEF});

    @(posedge clk);
    #1;
    foreach (tbl[i]) runCycle($sformatf("vec%0d", i), tbl[i].s, 1'b1, tbl[i].exp, 1'b0, O_RST);

    // Three-cycle load-use stall on the LUS=3 instance.
    runCycle("lus3_rst", rstS, 1'b1, O_RST, 1'b1, O_RST);
    runCycle("lus3_hz", mk(0, 0, 1, 5, 5, 1, 0, 0, 0), 1'b1, O_STALL, 1'b1, O_STALL);
    runCycle("lus3_s1", idle(), 1'b1, O_DEF, 1'b1, O_LST);
    runCycle("lus3_s2", idle(), 1'b1, O_DEF, 1'b1, O_LST);
    runCycle("lus3_done", idle(), 1'b1, O_DEF, 1'b1, O_DEF);

    // Reset asserted mid mul/div once the counter has reached 20.
    runCycle("md_rst0", rstS, 1'b1, O_RST, 1'b1, O_RST);
    runCycle("md_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, O_DEF, 1'b1, O_DEF);
    for (int k = 0; k < 11; k++) runCycle($sformatf("md_busy%0d", k), idle(), 1'b0, O_RST, 1'b1, O_MD);
    runCycle("md_rst1", rstS, 1'b1, O_RST, 1'b1, O_RST);
    runCycle("md_rst2", rstS, 1'b1, O_RST, 1'b1, O_RST);
    runCycle("md_after", idle(), 1'b1, O_DEF, 1'b1, O_DEF);

    for (int n = 0; n < 3000; n++) begin
      s.rst      = ($urandom_range(0, 99) == 0);
      s.br       = ($urandom_range(0, 7) == 0);
      s.mem_read = $urandom_range(0, 1) == 1;
      s.rd       = 5'($urandom_range(0, 3));
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.rs_use   = $urandom_range(0, 1) == 1;
      s.rt_use   = $urandom_range(0, 1) == 1;
      s.muldiv   = ($urandom_range(0, 5) == 0);
      runCycle($sformatf("rnd%0d", n), s, 1'b0, O_RST, 1'b0, O_RST);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
